// File: rtl/jpeg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : jpeg_pkg                                                     |
// | Description : Shared constants for the JPEG coefficient path: zigzag scan  |
// |               table, default coefficient width, FP32 field layout.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package jpeg_pkg;

  localparam int OUT_W_DEFAULT = 12;

  localparam int FP_W     = 32;
  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int FP_BIAS  = 127;

  typedef logic [5:0] blk_idx_t;

  // Raster address visited at each zigzag position; entry [0] is the DC term.
  // Listed from position 63 down to position 0 because of packed ordering.
  localparam logic [63:0][5:0] ZIGZAG_LUT = {
    6'd63, 6'd62, 6'd55, 6'd47, 6'd54, 6'd61, 6'd60, 6'd53,
    6'd46, 6'd39, 6'd31, 6'd38, 6'd45, 6'd52, 6'd59, 6'd58,
    6'd51, 6'd44, 6'd37, 6'd30, 6'd23, 6'd15, 6'd22, 6'd29,
    6'd36, 6'd43, 6'd50, 6'd57, 6'd56, 6'd49, 6'd42, 6'd35,
    6'd28, 6'd21, 6'd14, 6'd7,  6'd6,  6'd13, 6'd20, 6'd27,
    6'd34, 6'd41, 6'd48, 6'd40, 6'd33, 6'd26, 6'd19, 6'd12,
    6'd5,  6'd4,  6'd11, 6'd18, 6'd25, 6'd32, 6'd24, 6'd17,
    6'd10, 6'd3,  6'd2,  6'd9,  6'd16, 6'd8,  6'd1,  6'd0
  };

endpackage
`default_nettype wire

// File: rtl/fp_to_int.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fp_to_int                                                    |
// | Description : Combinational FP32 to saturated signed integer, rounding     |
// |               half away from zero. NaN gives 0, Inf saturates by sign.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fp_to_int
  import jpeg_pkg::*;
#(
  parameter int OUT_W = OUT_W_DEFAULT
) (
  input  logic [FP_W-1:0]  fp_i,
  output logic [OUT_W-1:0] int_o
);

  localparam int c_sig_w = FP_MAN_W + 1;
  // Smallest exponent that can round to a nonzero value (|x| >= 0.5).
  localparam logic [FP_EXP_W-1:0] c_exp_half  = FP_EXP_W'(FP_BIAS - 1);
  // From here on |x| >= 2^OUT_W, always beyond the signed range.
  localparam logic [FP_EXP_W-1:0] c_exp_sat   = FP_EXP_W'(FP_BIAS + OUT_W);
  // Right shift that leaves the magnitude with exactly one fraction bit.
  localparam logic [FP_EXP_W-1:0] c_shift_ref = FP_EXP_W'(FP_BIAS + FP_MAN_W - 1);
  localparam logic [c_sig_w-1:0]  c_pos_lim   = c_sig_w'((1 << (OUT_W - 1)) - 1);
  localparam logic [c_sig_w-1:0]  c_neg_lim   = c_sig_w'(1 << (OUT_W - 1));
  localparam logic [OUT_W-1:0]    c_max       = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]    c_min       = {1'b1, {(OUT_W-1){1'b0}}};

  logic                w_sign;
  logic [FP_EXP_W-1:0] w_exp;
  logic [FP_MAN_W-1:0] w_man;
  logic [FP_EXP_W-1:0] w_shamt;
  logic [c_sig_w-1:0]  w_mag2;
  logic [c_sig_w-1:0]  w_rnd;

  assign w_sign = fp_i[FP_W-1];
  assign w_exp  = fp_i[FP_W-2 -: FP_EXP_W];
  assign w_man  = fp_i[FP_MAN_W-1:0];

  // Magnitude with one fraction bit, round half up on it, then saturate and sign.
  always_comb begin
    w_shamt = c_shift_ref - w_exp;
    w_mag2  = {1'b1, w_man} >> w_shamt;
    w_rnd   = (w_mag2 + c_sig_w'(1)) >> 1;
    int_o   = '0;
    if (w_exp == '1) begin
      if (w_man == '0) begin
        int_o = w_sign ? c_min : c_max;
      end
    end else if (w_exp < c_exp_half) begin
      int_o = '0;
    end else if (w_exp >= c_exp_sat) begin
      int_o = w_sign ? c_min : c_max;
    end else if (!w_sign) begin
      int_o = (w_rnd > c_pos_lim) ? c_max : w_rnd[OUT_W-1:0];
    end else begin
      int_o = (w_rnd > c_neg_lim) ? c_min : (OUT_W'(0) - w_rnd[OUT_W-1:0]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/zigzag_reorder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : zigzag_reorder                                               |
// | Description : Converts column-major FP32 coefficients to saturated ints,   |
// |               buffers them in a ping-pong block store and emits each 8x8   |
// |               block in JPEG zigzag order over valid/ready.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module zigzag_reorder
  import jpeg_pkg::*;
#(
  parameter int OUT_W = OUT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_first,
  output logic             out_last
);

  localparam blk_idx_t c_idx_last = 6'd63;

  // Writer side: counter and bank select advance when a sample is accepted.
  blk_idx_t         wi_q;
  logic             wsel_q;
  logic [1:0]       full_q, full_d;

  // Conversion pipeline stage ahead of the bank write.
  logic             s1_valid_q;
  logic [OUT_W-1:0] s1_data_q;
  blk_idx_t         s1_addr_q;
  logic             s1_bank_q;
  logic             s1_last_q;

  // Reader side: ri/rsel point at the next element to load into the output.
  blk_idx_t         ri_q;
  logic             rsel_q;
  logic [OUT_W-1:0] out_data_q;
  logic             out_valid_q, out_first_q, out_last_q;

  logic [OUT_W-1:0] mem_q [2][64];

  logic             w_accept;
  logic             w_load;
  logic             w_bank_done;
  logic [OUT_W-1:0] w_conv;

  fp_to_int #(.OUT_W(OUT_W)) u_fp_to_int (
    .fp_i  (in_data),
    .int_o (w_conv)
  );

  assign w_load      = full_q[rsel_q] && (!out_valid_q || out_ready);
  assign w_bank_done = w_load && (ri_q == c_idx_last);
  // A bank whose last element is being read this cycle can take a new sample:
  // the write lands one cycle later, after every read of that bank is done.
  assign in_ready    = !full_q[wsel_q] || (w_bank_done && (rsel_q == wsel_q));
  assign w_accept    = in_valid && in_ready;

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;

  // Full flags: set on the write that completes a bank, released once its last element is read.
  always_comb begin
    full_d = full_q;
    if (s1_valid_q && s1_last_q) begin
      full_d[s1_bank_q] = 1'b1;
    end
    if (w_bank_done) begin
      full_d[rsel_q] = 1'b0;
    end
  end

  // Accept path: register the converted sample with its raster address and bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wi_q       <= '0;
      wsel_q     <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_addr_q  <= '0;
      s1_bank_q  <= 1'b0;
      s1_last_q  <= 1'b0;
      full_q     <= 2'b00;
    end else begin
      full_q     <= full_d;
      s1_valid_q <= w_accept;
      if (w_accept) begin
        s1_data_q <= w_conv;
        s1_addr_q <= {wi_q[2:0], wi_q[5:3]};
        s1_bank_q <= wsel_q;
        s1_last_q <= (wi_q == c_idx_last);
        wi_q      <= wi_q + 6'd1;
        if (wi_q == c_idx_last) begin
          wsel_q <= ~wsel_q;
        end
      end
    end
  end

  // Block storage write port.
  always_ff @(posedge clk) begin
    if (s1_valid_q) begin
      mem_q[s1_bank_q][s1_addr_q] <= s1_data_q;
    end
  end

  // Output register: load the next zigzag element when empty or being consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ri_q        <= '0;
      rsel_q      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else if (w_load) begin
      out_data_q  <= mem_q[rsel_q][ZIGZAG_LUT[ri_q]];
      out_valid_q <= 1'b1;
      out_first_q <= (ri_q == '0);
      out_last_q  <= (ri_q == c_idx_last);
      ri_q        <= ri_q + 6'd1;
      if (ri_q == c_idx_last) begin
        rsel_q <= ~rsel_q;
      end
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
    end
  end

endmodule
`default_nettype wire
